mem_wb_pipe: RTL
================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, 32, data/address/PC width; multiple of 8.
REQ-002 SHALL have parameter RD_W, 5, destination-register index width.
REQ-003 SHALL have parameter CNT_W, 32, performance-counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port en  in  1  segment enable; 0 = hold.
REQ-007 SHALL have port clear  in  1  flush; loads zeros when en=1.
REQ-008 SHALL have ports AluOutE/PCE  in  DATA_W  and matching outputs AluOutMW/PCMW  out  DATA_W.
REQ-009 SHALL have port RdE  in  RD_W  and output RdMW  out  RD_W.
REQ-010 SHALL have port RegWriteE  in  3  and output RegWriteMW  out  3.
REQ-011 SHALL have ports MemToRegE/LoadNpcE  in  1  and outputs MemToRegMW/LoadNpcMW  out  1.
REQ-012 SHALL have port MemWriteE  in  DATA_W/8  byte write enables; ForwardData2  in  DATA_W  store data.
REQ-013 SHALL have cache ports: CacheAddr/CacheWrData  out  DATA_W; CacheWrBe  out  DATA_W/8; CacheRdReq/CacheWrReq  out  1; CacheMiss  in  1; CacheRdData  in  DATA_W.
REQ-014 SHALL have port RD  out  DATA_W  load data to the writeback stage.
REQ-015 SHALL have port MemStall  out  1  pipeline stall request to the hazard unit.
REQ-016 SHALL have ports HitCnt/MissCnt  out  CNT_W  access statistics.

Function
REQ-017 SHALL, on a clock edge with en=1, load all *MW outputs from their E inputs, or load zeros when clear=1; with en=0 it SHALL hold them.
REQ-018 SHALL drive the cache combinationally: CacheAddr=AluOutE, CacheWrData=ForwardData2, CacheWrBe=MemWriteE, CacheRdReq=MemToRegE&~clear, CacheWrReq=|MemWriteE&~clear.
REQ-019 SHALL define access=CacheRdReq|CacheWrReq.
REQ-020 SHALL implement a two-state FSM, IDLE and MISS; IDLE goes to MISS on access&CacheMiss; MISS returns to IDLE when CacheMiss=0.
REQ-021 SHALL drive MemStall=access&CacheMiss in IDLE and MemStall=CacheMiss in MISS, combinationally (zero-cycle).
REQ-022 SHALL increment HitCnt once per cycle where state=IDLE, access=1, CacheMiss=0, en=1.
REQ-023 SHALL increment MissCnt exactly once per miss, on the MISS->IDLE transition, never per stall cycle.
REQ-024 SHALL saturate both counters at all-ones (no wrap).
REQ-025 SHALL keep MISS state when clear asserts mid-miss; the outstanding cache fill completes and is counted.
REQ-026 SHALL register flags stall_ff<=~en and clear_ff<=en&clear each edge, plus RD_hold<=RD when en=0, 0 when en=1&clear=1, 0 otherwise.
REQ-027 SHALL output RD=RD_hold when stall_ff|clear_ff, else CacheRdData.
REQ-028 SHALL give clear priority over data but en priority over clear (en=0 ignores clear).

Reset
REQ-029 SHALL, on rst=1 at a clock edge, zero every *MW output, RD_hold, stall_ff, clear_ff, HitCnt and MissCnt, and set FSM to IDLE.
REQ-030 SHALL abandon MISS on mid-miss reset without incrementing MissCnt; MemStall then follows the IDLE equation.

Configuration
REQ-031 SHALL compile counters and their update logic only when MW_PERF_CNT_EN is defined; without it HitCnt and MissCnt SHALL be constant 0, with FSM and MemStall unchanged.

Verification
REQ-032 SHALL check: load hit (MemToRegE=1, CacheMiss=0, en=1) -> MemStall=0, HitCnt 0->1, RD=CacheRdData next cycle.
REQ-033 SHALL check: store miss with CacheMiss high 5 cycles -> MemStall high 5 cycles, MissCnt +1 exactly, HitCnt unchanged.
REQ-034 SHALL check: en=0 for 3 cycles after load returns 0xDEADBEEF while CacheRdData changes -> RD stays 0xDEADBEEF until en returns.
REQ-035 SHALL check: clear=1, en=1 with RegWriteE=3'b010, RdE=7 -> RegWriteMW=0, RdMW=0, RD=0 next cycle, no cache request.
REQ-036 SHALL check: CNT_W=4, 20 hits -> HitCnt saturates at 15; rst mid-miss -> MissCnt unchanged, state IDLE.

Source files
------------

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB segment bus: execute-side inputs, writeback-side outputs, data-cache port and statistics.
// master = surrounding pipeline / cache, slave = the mem_wb_pipe segment.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
);
  logic                en;
  logic                clear;
  logic [DATA_W-1:0]   AluOutE;
  logic [DATA_W-1:0]   PCE;
  logic [RD_W-1:0]     RdE;
  logic [2:0]          RegWriteE;
  logic                MemToRegE;
  logic                LoadNpcE;
  logic [DATA_W/8-1:0] MemWriteE;
  logic [DATA_W-1:0]   ForwardData2;
  logic [DATA_W-1:0]   AluOutMW;
  logic [DATA_W-1:0]   PCMW;
  logic [RD_W-1:0]     RdMW;
  logic [2:0]          RegWriteMW;
  logic                MemToRegMW;
  logic                LoadNpcMW;
  logic [DATA_W-1:0]   CacheAddr;
  logic [DATA_W-1:0]   CacheWrData;
  logic [DATA_W/8-1:0] CacheWrBe;
  logic                CacheRdReq;
  logic                CacheWrReq;
  logic                CacheMiss;
  logic [DATA_W-1:0]   CacheRdData;
  logic [DATA_W-1:0]   RD;
  logic                MemStall;
  logic [CNT_W-1:0]    HitCnt;
  logic [CNT_W-1:0]    MissCnt;

  modport master (
    output en, clear, AluOutE, PCE, RdE, RegWriteE, MemToRegE, LoadNpcE, MemWriteE, ForwardData2,
           CacheMiss, CacheRdData,
    input  AluOutMW, PCMW, RdMW, RegWriteMW, MemToRegMW, LoadNpcMW, CacheAddr, CacheWrData, CacheWrBe,
           CacheRdReq, CacheWrReq, RD, MemStall, HitCnt, MissCnt
  );

  modport slave (
    input  en, clear, AluOutE, PCE, RdE, RegWriteE, MemToRegE, LoadNpcE, MemWriteE, ForwardData2,
           CacheMiss, CacheRdData,
    output AluOutMW, PCMW, RdMW, RegWriteMW, MemToRegMW, LoadNpcMW, CacheAddr, CacheWrData, CacheWrBe,
           CacheRdReq, CacheWrReq, RD, MemStall, HitCnt, MissCnt
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline segment with blocking data-cache miss FSM; 1-cycle register latency, zero-cycle MemStall,
// en=0 holds the segment. Hit/miss counters are built only when MW_PERF_CNT_EN is defined.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  mem_wb_pipe_if.slave bus
);
  typedef enum logic {IDLE, MISS} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rd_req;
  logic              wr_req;
  logic              access;
  logic              stall_ff;
  logic              clear_ff;
  logic [DATA_W-1:0] rd_hold;
  logic [DATA_W-1:0] rd_out;

  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] pc_q;
  logic [RD_W-1:0]   rd_q;
  logic [2:0]        regwr_q;
  logic              m2r_q;
  logic              npc_q;

  // A flushed instruction must never reach the cache.
  assign rd_req = bus.MemToRegE & ~bus.clear;
  assign wr_req = (|bus.MemWriteE) & ~bus.clear;
  assign access = rd_req | wr_req;

  assign bus.CacheAddr   = bus.AluOutE;
  assign bus.CacheWrData = bus.ForwardData2;
  assign bus.CacheWrBe   = bus.MemWriteE;
  assign bus.CacheRdReq  = rd_req;
  assign bus.CacheWrReq  = wr_req;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Once a fill is outstanding the stall tracks CacheMiss alone, so a flush cannot drop it.
  always_comb begin
    state_d      = state_q;
    bus.MemStall = 1'b0;
    case (state_q)
      IDLE: begin
        bus.MemStall = access & bus.CacheMiss;
        if (access && bus.CacheMiss) state_d = MISS;
      end
      MISS: begin
        bus.MemStall = bus.CacheMiss;
        if (!bus.CacheMiss) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      regwr_q <= '0;
      m2r_q   <= 1'b0;
      npc_q   <= 1'b0;
    end else if (bus.en) begin
      if (bus.clear) begin
        alu_q   <= '0;
        pc_q    <= '0;
        rd_q    <= '0;
        regwr_q <= '0;
        m2r_q   <= 1'b0;
        npc_q   <= 1'b0;
      end else begin
        alu_q   <= bus.AluOutE;
        pc_q    <= bus.PCE;
        rd_q    <= bus.RdE;
        regwr_q <= bus.RegWriteE;
        m2r_q   <= bus.MemToRegE;
        npc_q   <= bus.LoadNpcE;
      end
    end
  end

  assign bus.AluOutMW   = alu_q;
  assign bus.PCMW       = pc_q;
  assign bus.RdMW       = rd_q;
  assign bus.RegWriteMW = regwr_q;
  assign bus.MemToRegMW = m2r_q;
  assign bus.LoadNpcMW  = npc_q;

  // The cache only presents load data for one cycle; park it while the segment is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_ff <= 1'b0;
      clear_ff <= 1'b0;
      rd_hold  <= '0;
    end else begin
      stall_ff <= ~bus.en;
      clear_ff <= bus.en & bus.clear;
      rd_hold  <= bus.en ? '0 : rd_out;
    end
  end

  assign rd_out = (stall_ff | clear_ff) ? rd_hold : bus.CacheRdData;
  assign bus.RD = rd_out;

`ifdef MW_PERF_CNT_EN
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;
  logic             hit_inc;
  logic             miss_inc;

  assign hit_inc  = (state_q == IDLE) & access & ~bus.CacheMiss & bus.en;
  assign miss_inc = (state_q == MISS) & ~bus.CacheMiss;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_inc && !(&hit_q))   hit_q  <= hit_q + 1'b1;
      if (miss_inc && !(&miss_q)) miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.HitCnt  = hit_q;
  assign bus.MissCnt = miss_q;
`else
  assign bus.HitCnt  = {CNT_W{1'b0}};
  assign bus.MissCnt = {CNT_W{1'b0}};
`endif
endmodule
